// File: rtl/cdc_msg_deframer.sv
// cdc_msg_deframer
// Read-side consumer of the 125->250 MHz byte CDC. Recovers length-prefixed
// messages (2-byte big-endian length, then payload) from the byte stream and
// packs the payload into WORD_BYTES-wide words with SOP/EOP markers. Framing
// is re-established after errors by waiting for an idle gap on the input.
//
// Ports:
//   clkIn        250 MHz clock
//   rstIn        synchronous active-high reset
//   dataIn       byte from the CDC
//   dataValidIn  dataIn valid this cycle
//   dataErrIn    CDC tag mismatch, the byte is corrupt
//   wordOut      packed payload, first byte in the most significant lane
//   wordKeepOut  lane mask, MSB = first lane
//   wordValidOut single-cycle word strobe
//   wordSopOut   first word of a message (with wordValidOut)
//   wordEopOut   last word of a message (with wordValidOut)
//   msgLenOut    payload length, valid with wordEopOut
//   msgAbortOut  pulse: a message whose SOP was emitted is abandoned
//   lenErrOut    pulse: header length out of range
//   streamErrOut pulse: dataErrIn seen
//   msgCountOut  completed messages (CDC_MSG_DEFRAMER_STATS_EN)
//   errCountOut  lenErr + streamErr events (CDC_MSG_DEFRAMER_STATS_EN)
//
// Build option: define CDC_MSG_DEFRAMER_STATS_EN to enable the two saturating
// event counters; without it both counter outputs are tied to 0.
//
// state   | meaning
// HDR_HI  | waiting for length MSB
// HDR_LO  | waiting for length LSB
// PAYLOAD | packing payload bytes into words
// DROP    | discarding bytes until an idle gap resyncs the framer

module cdc_msg_deframer #(
  parameter int WORD_BYTES    = 8,
  parameter int MAX_MSG_BYTES = 1024,
  parameter int IDLE_GAP_CYC  = 16
) (
  input  logic                    clkIn,
  input  logic                    rstIn,
  input  logic [7:0]              dataIn,
  input  logic                    dataValidIn,
  input  logic                    dataErrIn,
  output logic [8*WORD_BYTES-1:0] wordOut,
  output logic [WORD_BYTES-1:0]   wordKeepOut,
  output logic                    wordValidOut,
  output logic                    wordSopOut,
  output logic                    wordEopOut,
  output logic [15:0]             msgLenOut,
  output logic                    msgAbortOut,
  output logic                    lenErrOut,
  output logic                    streamErrOut,
  output logic [15:0]             msgCountOut,
  output logic [15:0]             errCountOut
);

  localparam int LANE_W = $clog2(WORD_BYTES);
  localparam int IDLE_W = $clog2(IDLE_GAP_CYC + 1);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(WORD_BYTES - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(IDLE_GAP_CYC);
  localparam logic [IDLE_W-1:0] IDLE_HIT  = IDLE_W'(IDLE_GAP_CYC - 1);
  localparam logic [15:0]       MAX_LEN   = 16'(MAX_MSG_BYTES);

  typedef enum logic [1:0] {HDR_HI, HDR_LO, PAYLOAD, DROP} state_t;

  state_t                  state, stateNxt;
  logic [7:0]              lenHi, lenHiNxt;
  logic [15:0]             msgLen, msgLenNxt;
  logic [15:0]             remaining, remainingNxt;
  logic [LANE_W-1:0]       lane, laneNxt;
  logic [8*WORD_BYTES-1:0] packBuf, packBufNxt;
  logic                    sopDone, sopDoneNxt;
  logic [IDLE_W-1:0]       idleCnt, idleCntNxt;

  logic [8*WORD_BYTES-1:0] wordNxt;
  logic [WORD_BYTES-1:0]   keepNxt;
  logic                    validNxt, sopNxt, eopNxt;
  logic                    abortNxt, lenErrNxt, streamErrNxt;
  logic [15:0]             lenOutNxt;

  logic [15:0]             hdrLen;
  logic [8*WORD_BYTES-1:0] packWithByte;
  logic [WORD_BYTES-1:0]   keepWithByte;
  logic [WORD_BYTES-1:0]   allLanes;

  assign hdrLen   = {lenHi, dataIn};
  assign allLanes = '1;
  // lanes 0..lane are occupied once the current byte lands
  assign keepWithByte = ~(allLanes >> (int'(lane) + 1));

  always_comb begin
    packWithByte = packBuf;
    packWithByte[(WORD_BYTES - 1 - int'(lane)) * 8 +: 8] = dataIn;
  end

  always_comb begin
    stateNxt     = state;
    lenHiNxt     = lenHi;
    msgLenNxt    = msgLen;
    remainingNxt = remaining;
    laneNxt      = lane;
    packBufNxt   = packBuf;
    sopDoneNxt   = sopDone;
    idleCntNxt   = idleCnt;
    wordNxt      = '0;
    keepNxt      = '0;
    validNxt     = 1'b0;
    sopNxt       = 1'b0;
    eopNxt       = 1'b0;
    lenOutNxt    = '0;
    abortNxt     = 1'b0;
    lenErrNxt    = 1'b0;
    streamErrNxt = 1'b0;

    if (dataErrIn) begin
      // a corrupt byte always wins, even when flagged valid
      streamErrNxt = 1'b1;
      abortNxt     = (state == PAYLOAD) && sopDone;
      stateNxt     = DROP;
      laneNxt      = '0;
      packBufNxt   = '0;
      sopDoneNxt   = 1'b0;
      if (dataValidIn) idleCntNxt = '0;
    end else if (dataValidIn) begin
      idleCntNxt = '0;
      case (state)
        HDR_HI: begin
          lenHiNxt = dataIn;
          stateNxt = HDR_LO;
        end
        HDR_LO: begin
          if (hdrLen == 16'd0) begin
            stateNxt = HDR_HI;
          end else if (hdrLen > MAX_LEN) begin
            lenErrNxt = 1'b1;
            stateNxt  = DROP;
          end else begin
            msgLenNxt    = hdrLen;
            remainingNxt = hdrLen;
            laneNxt      = '0;
            packBufNxt   = '0;
            sopDoneNxt   = 1'b0;
            stateNxt     = PAYLOAD;
          end
        end
        PAYLOAD: begin
          remainingNxt = remaining - 16'd1;
          if (lane == LAST_LANE || remaining == 16'd1) begin
            wordNxt    = packWithByte;
            keepNxt    = keepWithByte;
            validNxt   = 1'b1;
            sopNxt     = !sopDone;
            sopDoneNxt = 1'b1;
            laneNxt    = '0;
            packBufNxt = '0;
            if (remaining == 16'd1) begin
              eopNxt    = 1'b1;
              lenOutNxt = msgLen;
              stateNxt  = HDR_HI;
            end
          end else begin
            laneNxt    = lane + LANE_W'(1);
            packBufNxt = packWithByte;
          end
        end
        default: ;
      endcase
    end else if (state != HDR_HI) begin
      if (idleCnt != IDLE_MAX) idleCntNxt = idleCnt + IDLE_W'(1);
      if (idleCnt == IDLE_HIT) begin
        // idle gap marks a frame boundary: resync, abandoning any partial message
        abortNxt   = (state == PAYLOAD) && sopDone;
        stateNxt   = HDR_HI;
        laneNxt    = '0;
        packBufNxt = '0;
        sopDoneNxt = 1'b0;
      end
    end

    if (stateNxt == HDR_HI) idleCntNxt = '0;
  end

  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      state        <= HDR_HI;
      lenHi        <= '0;
      msgLen       <= '0;
      remaining    <= '0;
      lane         <= '0;
      packBuf      <= '0;
      sopDone      <= 1'b0;
      idleCnt      <= '0;
      wordOut      <= '0;
      wordKeepOut  <= '0;
      wordValidOut <= 1'b0;
      wordSopOut   <= 1'b0;
      wordEopOut   <= 1'b0;
      msgLenOut    <= '0;
      msgAbortOut  <= 1'b0;
      lenErrOut    <= 1'b0;
      streamErrOut <= 1'b0;
    end else begin
      state        <= stateNxt;
      lenHi        <= lenHiNxt;
      msgLen       <= msgLenNxt;
      remaining    <= remainingNxt;
      lane         <= laneNxt;
      packBuf      <= packBufNxt;
      sopDone      <= sopDoneNxt;
      idleCnt      <= idleCntNxt;
      wordOut      <= wordNxt;
      wordKeepOut  <= keepNxt;
      wordValidOut <= validNxt;
      wordSopOut   <= sopNxt;
      wordEopOut   <= eopNxt;
      msgLenOut    <= lenOutNxt;
      msgAbortOut  <= abortNxt;
      lenErrOut    <= lenErrNxt;
      streamErrOut <= streamErrNxt;
    end
  end

`ifdef CDC_MSG_DEFRAMER_STATS_EN
  logic [15:0] msgCount;
  logic [15:0] errCount;

  // counted from the next-state pulses so the counters move with the outputs
  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      msgCount <= '0;
      errCount <= '0;
    end else begin
      if (validNxt && eopNxt && msgCount != 16'hFFFF) msgCount <= msgCount + 16'd1;
      if ((lenErrNxt || streamErrNxt) && errCount != 16'hFFFF) errCount <= errCount + 16'd1;
    end
  end

  assign msgCountOut = msgCount;
  assign errCountOut = errCount;
`else
  assign msgCountOut = '0;
  assign errCountOut = '0;
`endif

endmodule
